// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer write arbiter.
// Used by fb_write_arbiter and fb_addr_calc.
package fb_pkg;

  localparam int H_RES_DEF   = 640;
  localparam int V_RES_DEF   = 400;
  localparam int ADDR_W_DEF  = 19;
  localparam int COORD_W_DEF = 10;

  typedef logic [COORD_W_DEF-1:0] coord_t;
  typedef logic [ADDR_W_DEF-1:0]  fb_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fill_state_t;

  typedef enum logic {
    REQ_HOST,
    REQ_FILL
  } requester_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Registered (x,y) to linear address stage with range check.
// Out-of-range pixels produce a drop strobe instead of a write.
module fb_addr_calc
  import fb_pkg::*;
#(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_valid,
  input  logic [COORD_W:0]   i_x,
  input  logic [COORD_W:0]   i_y,
  input  logic [7:0]         i_lum,
  output logic               o_we,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [7:0]         o_data,
  output logic               o_drop
);

  logic [ADDR_W-1:0] w_lin;
  logic              w_in;

  assign w_lin = ADDR_W'(32'(i_y) * 32'(H_RES) + 32'(i_x));
  assign w_in  = (32'(i_x) < 32'(H_RES)) &&
                 (32'(i_y) < 32'(V_RES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_we   <= 1'b0;
      o_addr <= '0;
      o_data <= '0;
      o_drop <= 1'b0;
    end else begin
      o_we   <= i_valid && w_in;
      o_drop <= i_valid && !w_in;
      if (i_valid) begin
        o_addr <= w_lin;
        o_data <= i_lum;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin owner of the framebuffer write port: host pixels + rect fill.
// Optional FB_VBLANK_GATE_EN adds a vblank input that gates all grants.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
`ifdef FB_VBLANK_GATE_EN
  input  logic               vblank,
`endif
  input  logic               host_valid,
  output logic               host_ready,
  input  logic [COORD_W-1:0] host_x,
  input  logic [COORD_W-1:0] host_y,
  input  logic [7:0]         host_lum,
  input  logic               fill_start,
  input  logic [COORD_W-1:0] fill_x0,
  input  logic [COORD_W-1:0] fill_y0,
  input  logic [COORD_W-1:0] fill_w,
  input  logic [COORD_W-1:0] fill_h,
  input  logic [7:0]         fill_lum,
  output logic               fill_busy,
  output logic               fill_done,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [7:0]         fb_data,
  output logic [15:0]        drop_cnt
);

  localparam logic [COORD_W:0] C_ONE = {{COORD_W{1'b0}}, 1'b1};

  fill_state_t      r_state;
  requester_t       r_rr_last;
  logic [COORD_W:0] r_x0, r_xe, r_ye, r_cx, r_cy;
  logic [7:0]       r_lum;
  logic             r_busy, r_done;
  logic [15:0]      r_drop_cnt;

  logic             w_gate, w_fill_req, w_host_gnt, w_fill_gnt;
  logic [COORD_W:0] w_gx, w_gy;
  logic [7:0]       w_glum;
  logic             w_drop;

`ifdef FB_VBLANK_GATE_EN
  assign w_gate = vblank;
`else
  assign w_gate = 1'b1;
`endif

  assign w_fill_req = (r_state == RUN);
  // Ready is held low while reset is asserted so all outputs read 0.
  assign host_ready = !reset && w_gate &&
                      (!w_fill_req || r_rr_last == REQ_FILL);
  assign w_host_gnt = host_valid && host_ready;
  assign w_fill_gnt = w_fill_req && w_gate && !w_host_gnt;

  assign w_gx   = w_host_gnt ? {1'b0, host_x} : r_cx;
  assign w_gy   = w_host_gnt ? {1'b0, host_y} : r_cy;
  assign w_glum = w_host_gnt ? host_lum : r_lum;

  assign fill_busy = r_busy;
  assign fill_done = r_done;
  assign drop_cnt  = r_drop_cnt;

  fb_addr_calc #(
    .H_RES   (H_RES),
    .V_RES   (V_RES),
    .ADDR_W  (ADDR_W),
    .COORD_W (COORD_W)
  ) u_addr (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_host_gnt || w_fill_gnt),
    .i_x     (w_gx),
    .i_y     (w_gy),
    .i_lum   (w_glum),
    .o_we    (fb_we),
    .o_addr  (fb_addr),
    .o_data  (fb_data),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rr_last <= REQ_FILL;
      r_x0      <= '0;
      r_xe      <= '0;
      r_ye      <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_lum     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_host_gnt)
        r_rr_last <= REQ_HOST;
      else if (w_fill_gnt)
        r_rr_last <= REQ_FILL;
      unique case (r_state)
        IDLE: begin
          if (fill_start) begin
            r_x0  <= {1'b0, fill_x0};
            r_cx  <= {1'b0, fill_x0};
            r_cy  <= {1'b0, fill_y0};
            r_xe  <= {1'b0, fill_x0} + {1'b0, fill_w} - C_ONE;
            r_ye  <= {1'b0, fill_y0} + {1'b0, fill_h} - C_ONE;
            r_lum <= fill_lum;
            if (fill_w == '0 || fill_h == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_fill_gnt) begin
            if (r_cx == r_xe) begin
              r_cx <= r_x0;
              r_cy <= r_cy + C_ONE;
              if (r_cy == r_ye) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_cx <= r_cx + C_ONE;
            end
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 16'hFFFF)
      r_drop_cnt <= r_drop_cnt + 16'd1;
  end

endmodule
